zap_ram_fifo_ctrl: RTL
======================

ZAP_RAM_FIFO_CTRL -- requirements
Module: zap_ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning RAM entries; power of two, >= 4.
REQ-003 The block SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_reset  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_clear  in  1  synchronous flush.
REQ-006 The block SHALL have port i_wr_valid  in  1  push request.
REQ-007 The block SHALL have port i_wr_data  in  WIDTH  push data.
REQ-008 The block SHALL have port o_wr_ready  out  1  push accepted when high.
REQ-009 The block SHALL have port o_rd_valid  out  1  head data valid.
REQ-010 The block SHALL have port o_rd_data  out  WIDTH  head data.
REQ-011 The block SHALL have port i_rd_ready  in  1  consumer accepts head.
REQ-012 The block SHALL have port o_level  out  $clog2(DEPTH+2)+1  total entries held.
REQ-013 The block SHALL have ports o_ram_wr_en (1), o_ram_wr_addr ($clog2(DEPTH)), o_ram_wr_data (WIDTH), o_ram_rd_en (1) and o_ram_rd_addr ($clog2(DEPTH)), all out, driving an external 1R+1W RAM with 1-cycle registered read.
REQ-014 The block SHALL have port i_ram_rd_data  in  WIDTH  RAM read data, valid the cycle after o_ram_rd_en.
REQ-015 The block SHALL have ports o_overflow and o_underflow, out, 1 bit each, sticky error flags (see Configuration).

Function
REQ-016 Push SHALL occur when i_wr_valid and o_wr_ready; o_wr_ready = (ram_count < DEPTH) and not i_clear.
REQ-017 A push SHALL drive o_ram_wr_en=1, o_ram_wr_addr=wr_ptr, o_ram_wr_data=i_wr_data combinationally in the same cycle; wr_ptr increments modulo DEPTH.
REQ-018 ram_count SHALL count entries written but not yet read-issued; pointers SHALL wrap DEPTH-1 -> 0.
REQ-019 The output stage SHALL be a 2-entry skid buffer; o_rd_valid = skid non-empty; o_rd_data = oldest skid entry.
REQ-020 Pop SHALL occur when o_rd_valid and i_rd_ready; i_rd_ready with o_rd_valid low SHALL be an underflow attempt, ignored.
REQ-021 A RAM read SHALL be issued (o_ram_rd_en=1, o_ram_rd_addr=rd_ptr) when ram_count > 0 and skid_occ + inflight - pop < 2; rd_ptr increments modulo DEPTH.
REQ-022 inflight (1 bit) SHALL be set on read issue and cleared the next cycle, when i_ram_rd_data is written into the skid buffer.
REQ-023 No read SHALL target an entry written in the same cycle; earliest read issue is the cycle after push.
REQ-024 Empty-FIFO latency: push in cycle T -> read issued T+1 -> o_rd_valid high T+3.
REQ-025 Sustained throughput SHALL be 1 push and 1 pop per cycle with no bubbles once o_rd_valid is high.
REQ-026 Simultaneous push and pop SHALL both complete; when ram_count = DEPTH, the same-cycle read issue SHALL not raise o_wr_ready that cycle.
REQ-027 o_level SHALL equal ram_count + inflight + skid_occ, max DEPTH+2.
REQ-028 i_clear SHALL zero pointers, ram_count, inflight, skid and o_level at the next edge, overriding push, pop and read issue; RAM read data returning afterwards SHALL be discarded.

Reset
REQ-029 On i_reset, wr_ptr, rd_ptr, ram_count, inflight and skid_occ SHALL go to 0; o_rd_valid=0, o_level=0, o_overflow=0, o_underflow=0, o_ram_wr_en=0, o_ram_rd_en=0.
REQ-030 Reset asserted mid-operation SHALL discard all contents; o_wr_ready SHALL be 1 in the first cycle after deassertion.
REQ-031 Skid data registers SHALL not require reset; o_rd_data is don't-care while o_rd_valid=0.

Configuration
REQ-032 With macro ZAP_FIFO_CTRL_ERR_EN defined, o_overflow SHALL set on i_wr_valid with o_wr_ready=0, o_underflow SHALL set on REQ-020 underflow attempt; both clear only on i_reset or i_clear.
REQ-033 Without ZAP_FIFO_CTRL_ERR_EN, o_overflow and o_underflow SHALL be tied 0 and no error logic synthesized.

Verification
REQ-034 Single push 0xA5A5A5A5 into empty FIFO, i_rd_ready=1 -> o_rd_valid high exactly 3 cycles later with o_rd_data 0xA5A5A5A5, o_level 1 -> 0 after pop.
REQ-035 DEPTH=16, 18 pushes with i_rd_ready=0 -> o_level=18, o_wr_ready=0; 19th push refused (o_overflow=1 with macro); draining returns 18 values in order.
REQ-036 Continuous push/pop of incrementing data for 100 cycles -> no bubbles after fill, in-order data across at least 6 pointer wrap-arounds.
REQ-037 i_clear with o_level=10 and a read in flight -> o_level=0, o_rd_valid=0 next cycle; later push 0x1 emerges first.
REQ-038 i_reset asserted asynchronously mid-burst -> all outputs at reset values immediately; o_wr_ready=1 first cycle after release.
REQ-039 i_rd_ready=1 on empty FIFO -> no state change; o_underflow=1 with macro, 0 without.

Source files
------------

// File: rtl/zap_ram_fifo_ctrl.sv
// zap_ram_fifo_ctrl: FIFO controller for an external 1R1W RAM with 2-entry output skid.
// Optional macro ZAP_FIFO_CTRL_ERR_EN enables sticky overflow/underflow flags.
module zap_ram_fifo_ctrl #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 2) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_wr_valid,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_wr_ready,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_rd_ready,
    output logic [LW-1:0]    o_level,
    output logic             o_ram_wr_en,
    output logic [AW-1:0]    o_ram_wr_addr,
    output logic [WIDTH-1:0] o_ram_wr_data,
    output logic             o_ram_rd_en,
    output logic [AW-1:0]    o_ram_rd_addr,
    input  logic [WIDTH-1:0] i_ram_rd_data,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [AW:0] RAM_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ram_count;
    logic             inflight;
    logic [1:0]       skid_occ;
    logic [WIDTH-1:0] skid0;
    logic [WIDTH-1:0] skid1;

    logic             wr_ready;
    logic             rd_valid;
    logic             push;
    logic             pop;
    logic             rd_issue;
    logic [2:0]       occ_after;
    logic [1:0]       wpos;
    logic [AW:0]      ram_count_nxt;
    logic [WIDTH-1:0] skid0_nxt;
    logic [WIDTH-1:0] skid1_nxt;

    // Readiness depends only on registered count, so a same-cycle read
    // issue never frees a slot for the push in that cycle.
    assign wr_ready = !i_reset && !i_clear && (ram_count != RAM_FULL);
    assign rd_valid = (skid_occ != 2'd0);
    assign push     = i_wr_valid && wr_ready;
    assign pop      = rd_valid && i_rd_ready;

    assign occ_after = 3'(skid_occ) + 3'(inflight) - 3'(pop);

    // Only entries counted before this edge are readable, so a word being
    // written this cycle is never the read target.
    assign rd_issue = !i_clear && (ram_count != '0) && (occ_after < 3'd2);

    assign ram_count_nxt = ram_count + (AW + 1)'(push) - (AW + 1)'(rd_issue);

    assign wpos = skid_occ - {1'b0, pop};

    always_comb begin
        skid0_nxt = skid0;
        skid1_nxt = skid1;
        if (pop) begin
            skid0_nxt = skid1;
        end
        if (inflight) begin
            if (wpos == 2'd0) begin
                skid0_nxt = i_ram_rd_data;
            end else begin
                skid1_nxt = i_ram_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
            skid_occ  <= 2'd0;
        end else if (i_clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
            skid_occ  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_count <= ram_count_nxt;
            inflight  <= rd_issue;
            skid_occ  <= occ_after[1:0];
        end
    end

    // Skid payload is qualified by skid_occ, so it carries no reset.
    always_ff @(posedge i_clk) begin
        skid0 <= skid0_nxt;
        skid1 <= skid1_nxt;
    end

    assign o_wr_ready    = wr_ready;
    assign o_rd_valid    = rd_valid;
    assign o_rd_data     = skid0;
    assign o_ram_wr_en   = push;
    assign o_ram_wr_addr = wr_ptr;
    assign o_ram_wr_data = i_wr_data;
    assign o_ram_rd_en   = rd_issue;
    assign o_ram_rd_addr = rd_ptr;
    assign o_level       = LW'(ram_count) + LW'(inflight) + LW'(skid_occ);

`ifdef ZAP_FIFO_CTRL_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (i_clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_wr_valid && !wr_ready) begin
                overflow_q <= 1'b1;
            end
            if (i_rd_ready && !rd_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`else
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

endmodule
